ibex_bus_arbiter: RTL and testbench

IBEX_BUS_ARBITER -- requirements
Module: ibex_bus_arbiter
Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2: maximum granted, un-responded host transactions (1..4).
REQ-002 SHALL have parameter RoundRobin, default 1'b0: 0 = data always wins, 1 = alternate winner on contention.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port instr_req_i  input  1  fetch request, held until instr_gnt_o.
REQ-006 SHALL have port instr_gnt_o  output  1  fetch request accepted by host.
REQ-007 SHALL have port instr_rvalid_o  output  1  fetch response valid.
REQ-008 SHALL have port instr_addr_i  input  32  fetch address.
REQ-009 SHALL have port instr_rdata_o  output  32  fetch response data.
REQ-010 SHALL have port instr_err_o  output  1  fetch bus error, valid with instr_rvalid_o.
REQ-011 SHALL have port data_req_i  input  1  load/store request, held until data_gnt_o.
REQ-012 SHALL have port data_gnt_o  output  1  load/store accepted by host.
REQ-013 SHALL have port data_rvalid_o  output  1  load/store response valid.
REQ-014 SHALL have port data_we_i  input  1  write enable.
REQ-015 SHALL have port data_be_i  input  4  byte enables.
REQ-016 SHALL have port data_addr_i  input  32  load/store address.
REQ-017 SHALL have port data_wdata_i  input  32  store data.
REQ-018 SHALL have port data_rdata_o  output  32  load data.
REQ-019 SHALL have port data_err_o  output  1  load/store bus error, valid with data_rvalid_o.
REQ-020 SHALL have port host_req_o  output  1  shared-bus request.
REQ-021 SHALL have port host_gnt_i  input  1  shared-bus grant.
REQ-022 SHALL have port host_rvalid_i  input  1  shared-bus response, in grant order.
REQ-023 SHALL have port host_we_o  output  1  shared-bus write enable.
REQ-024 SHALL have port host_be_o  output  4  shared-bus byte enables.
REQ-025 SHALL have port host_addr_o  output  32  shared-bus address.
REQ-026 SHALL have port host_wdata_o  output  32  shared-bus write data.
REQ-027 SHALL have port host_rdata_i  input  32  shared-bus read data.
REQ-028 SHALL have port host_err_i  input  1  shared-bus error.
Function
REQ-029 SHALL run FSM states IDLE, HOLD_INSTR, HOLD_DATA; HOLD_x locks host outputs to owner x until host_gnt_i.
REQ-030 SHALL, in IDLE with any request and outstanding count < MaxOutstanding, pick winner combinationally (data if RoundRobin=0; on contention with RoundRobin=1, requester not granted last) and drive host_req_o=1 that cycle.
REQ-031 SHALL, in IDLE with winner and no host_gnt_i, move to HOLD_winner; in HOLD_x on host_gnt_i return to IDLE; no re-arbitration while in HOLD_x.
REQ-032 SHALL assert owner's gnt_o only as host_gnt_i & host_req_o in the same cycle (zero-latency grant) and push owner ID into the in-order owner FIFO on that cycle.
REQ-033 SHALL drive host_we_o=0, host_be_o=4'hF, host_wdata_o=0 for instruction ownership; data fields pass through for data ownership; all host outputs 0 when host_req_o=0.
REQ-034 SHALL hold host_req_o=0 and grant nothing when FIFO holds MaxOutstanding entries, except a same-cycle host_rvalid_i pop SHALL NOT free a slot until the next cycle.
REQ-035 SHALL route host_rvalid_i/host_rdata_i/host_err_i to FIFO-head owner same cycle (zero latency) and pop; rdata_o of the non-owner SHALL be 0.
REQ-036 SHALL support simultaneous push and pop (count unchanged); host_rvalid_i with empty FIFO SHALL be dropped with no output asserted.
REQ-037 SHALL update last-winner register only on a granted cycle.
Reset
REQ-038 SHALL on rst_ni low asynchronously set FSM=IDLE, FIFO empty, count=0, last-winner=instr; all outputs 0 during reset.
REQ-039 SHALL discard outstanding owner IDs on reset mid-operation; responses arriving after reset are dropped per REQ-036.
Structure
REQ-040 SHALL place typedef bus_owner_e (OwnerInstr=1'b0, OwnerData=1'b1) and arb_state_e in ibex_pkg.
REQ-041 SHALL implement the owner FIFO as sub-module ibex_bus_owner_fifo (Depth=MaxOutstanding, 1-bit entries, full/empty flags).
Verification
REQ-042 SHALL test both requests one cycle, RoundRobin=0, host_gnt_i=1 -> data granted, instr_gnt_o=0, host_addr_o=data_addr_i.
REQ-043 SHALL test RoundRobin=1, both requesting continuously, host_gnt_i=1 -> grants alternate D,I,D,I.
REQ-044 SHALL test instr granted, then data granted, rvalid rdata 32'hA5A5_0001 then 32'h0000_BEEF -> instr_rdata_o=A5A50001 first, data_rdata_o=0000BEEF second.
REQ-045 SHALL test host_gnt_i low 3 cycles with instr held, data_req_i raised -> host_addr_o stays instr address until grant.
REQ-046 SHALL test MaxOutstanding=2, two grants, no rvalid -> host_req_o=0; one rvalid -> host_req_o=1 next cycle.
REQ-047 SHALL test rst_ni low with 2 outstanding, then stray host_rvalid_i -> no rvalid_o asserted, FIFO empty.

---
 rtl/ibex_pkg.sv | 32 +++
 rtl/ibex_bus_owner_fifo.sv | 60 ++++++
 rtl/ibex_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_ibex_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the Ibex shared-bus arbiter: owner identifiers, arbiter FSM
// states and the winner-selection rule used in the idle state.
package ibex_pkg;

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } bus_owner_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_INSTR = 2'd1,
    HOLD_DATA  = 2'd2
  } arb_state_e;

  // On contention data wins, unless round-robin favours whoever lost last time.
  function automatic bus_owner_e pick_winner(input logic       instr_req,
                                             input logic       data_req,
                                             input logic       round_robin,
                                             input bus_owner_e last_winner);
    bus_owner_e winner;
    if (instr_req && data_req) begin
      winner = (round_robin && last_winner == OwnerData) ? OwnerInstr : OwnerData;
    end else if (data_req) begin
      winner = OwnerData;
    end else begin
      winner = OwnerInstr;
    end
    return winner;
  endfunction

endpackage

// File: rtl/ibex_bus_owner_fifo.sv
// In-order record of which requester owns each granted, un-responded host
// transaction; the head names the destination of the next response.
module ibex_bus_owner_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  bus_owner_e push_owner,
  input  logic       pop,
  output bus_owner_e head,
  output logic       full,
  output logic       empty
);

  localparam logic [1:0] LastIdx  = 2'(Depth - 1);
  localparam logic [2:0] DepthCnt = 3'(Depth);

  logic [3:0] mem_q;
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       do_push;
  logic       do_pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
    return (ptr == LastIdx) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == 3'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = bus_owner_e'(mem_q[rd_ptr_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_owner;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// Shares one host bus between the instruction-fetch and load/store ports with
// zero-latency grant and response routing; responses return in grant order.
module ibex_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  input  logic        host_rvalid_i,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_addr_o,
  output logic [31:0] host_wdata_o,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i
);

  arb_state_e state_q, state_d;
  bus_owner_e last_q;
  bus_owner_e owner;
  bus_owner_e head;
  logic       req_active;
  logic       granted;
  logic       resp_valid;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= OwnerInstr;
    end else begin
      state_q <= state_d;
      if (granted) begin
        last_q <= owner;
      end
    end
  end

  // Once a request is on the bus without a grant, it stays with the same owner.
  always_comb begin
    state_d    = state_q;
    owner      = OwnerInstr;
    req_active = 1'b0;
    case (state_q)
      IDLE: begin
        if ((instr_req_i || data_req_i) && !fifo_full) begin
          req_active = 1'b1;
          owner      = pick_winner(instr_req_i, data_req_i, RoundRobin, last_q);
          if (!host_gnt_i) begin
            state_d = (owner == OwnerData) ? HOLD_DATA : HOLD_INSTR;
          end
        end
      end
      HOLD_INSTR: begin
        owner      = OwnerInstr;
        req_active = !fifo_full;
        if (host_gnt_i && req_active) begin
          state_d = IDLE;
        end
      end
      default: begin
        owner      = OwnerData;
        req_active = !fifo_full;
        if (host_gnt_i && req_active) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign host_req_o  = req_active & rst_ni;
  assign granted     = host_req_o & host_gnt_i;
  assign instr_gnt_o = granted & (owner == OwnerInstr);
  assign data_gnt_o  = granted & (owner == OwnerData);

  always_comb begin
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_addr_o  = 32'h0;
    host_wdata_o = 32'h0;
    if (host_req_o) begin
      if (owner == OwnerData) begin
        host_we_o    = data_we_i;
        host_be_o    = data_be_i;
        host_addr_o  = data_addr_i;
        host_wdata_o = data_wdata_i;
      end else begin
        host_be_o   = 4'hF;
        host_addr_o = instr_addr_i;
      end
    end
  end

  // Responses with nothing outstanding have no owner and are discarded.
  assign resp_valid     = host_rvalid_i & ~fifo_empty & rst_ni;
  assign instr_rvalid_o = resp_valid & (head == OwnerInstr);
  assign data_rvalid_o  = resp_valid & (head == OwnerData);
  assign instr_rdata_o  = instr_rvalid_o ? host_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? host_rdata_i : 32'h0;
  assign instr_err_o    = instr_rvalid_o & host_err_i;
  assign data_err_o     = data_rvalid_o & host_err_i;

  ibex_bus_owner_fifo #(
    .Depth(MaxOutstanding)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (granted),
    .push_owner(owner),
    .pop       (resp_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Checks a fixed-priority and a round-robin arbiter instance against a
// queue-based model of the bus ownership rules, with directed and random traffic.
module tb_ibex_bus_arbiter;
  import ibex_pkg::*;

  localparam int MaxOut = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata, host_rdata;
  logic [3:0]  data_be;
  logic        host_gnt, host_rvalid, host_err;

  logic        a_hreq, a_igt, a_dgt, a_irv, a_drv, a_ierr, a_derr, a_we;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_irdata, a_drdata;
  logic        b_hreq, b_igt, b_dgt, b_irv, b_drv, b_ierr, b_derr, b_we;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_irdata, b_drdata;

  typedef struct packed {
    logic        hreq, igt, dgt, irv, drv, ierr, derr, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, irdata, drdata;
  } view_t;

  int total = 0;
  int bad   = 0;
  bit check_b = 1'b1;

  // Model: one queue entry per outstanding transaction, bit k = owner in instance k.
  logic [1:0] mq[$];
  bit         mlast[2];
  int         mlock[2];
  int         mown[2];
  bit         rr_mode[2] = '{1'b0, 1'b1};
  view_t      ev[2];

  always #5 clk_i = ~clk_i;

  ibex_bus_arbiter #(.MaxOutstanding(MaxOut), .RoundRobin(1'b0)) dut_fixed (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(a_igt), .instr_rvalid_o(a_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(a_irdata), .instr_err_o(a_ierr),
    .data_req_i(data_req), .data_gnt_o(a_dgt), .data_rvalid_o(a_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(a_drdata), .data_err_o(a_derr),
    .host_req_o(a_hreq), .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid),
    .host_we_o(a_we), .host_be_o(a_be), .host_addr_o(a_addr),
    .host_wdata_o(a_wdata), .host_rdata_i(host_rdata), .host_err_i(host_err)
  );

  ibex_bus_arbiter #(.MaxOutstanding(MaxOut), .RoundRobin(1'b1)) dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(b_igt), .instr_rvalid_o(b_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(b_irdata), .instr_err_o(b_ierr),
    .data_req_i(data_req), .data_gnt_o(b_dgt), .data_rvalid_o(b_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(b_drdata), .data_err_o(b_derr),
    .host_req_o(b_hreq), .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid),
    .host_we_o(b_we), .host_be_o(b_be), .host_addr_o(b_addr),
    .host_wdata_o(b_wdata), .host_rdata_i(host_rdata), .host_err_i(host_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic view_t model_view(input int k);
    view_t v = '0;
    bit    full = (mq.size() >= MaxOut);
    int    own = 0;
    if (!rst_ni) return v;
    if (mlock[k] >= 0) begin
      own    = mlock[k];
      v.hreq = !full;
    end else if ((instr_req || data_req) && !full) begin
      v.hreq = 1'b1;
      if (instr_req && data_req) own = (rr_mode[k] && mlast[k]) ? 0 : 1;
      else                       own = data_req ? 1 : 0;
    end
    mown[k] = own;
    if (v.hreq) begin
      if (own == 1) begin
        v.we = data_we; v.be = data_be; v.addr = data_addr; v.wdata = data_wdata;
      end else begin
        v.be = 4'hF; v.addr = instr_addr;
      end
      v.igt = host_gnt && own == 0;
      v.dgt = host_gnt && own == 1;
    end
    if (host_rvalid && mq.size() > 0) begin
      if (mq[0][k]) begin
        v.drv = 1'b1; v.derr = host_err; v.drdata = host_rdata;
      end else begin
        v.irv = 1'b1; v.ierr = host_err; v.irdata = host_rdata;
      end
    end
    return v;
  endfunction

  task automatic compare_view(input string who, input view_t o, input view_t e);
    chk({who, ".flags"}, 32'({o.hreq, o.igt, o.dgt, o.irv, o.drv, o.ierr, o.derr, o.we}),
                         32'({e.hreq, e.igt, e.dgt, e.irv, e.drv, e.ierr, e.derr, e.we}));
    chk({who, ".be"}, 32'(o.be), 32'(e.be));
    chk({who, ".addr"}, o.addr, e.addr);
    chk({who, ".wdata"}, o.wdata, e.wdata);
    chk({who, ".instr_rdata"}, o.irdata, e.irdata);
    chk({who, ".data_rdata"}, o.drdata, e.drdata);
  endtask

  task automatic model_reset();
    mq.delete();
    mlast = '{1'b0, 1'b0};
    mlock = '{-1, -1};
  endtask

  task automatic step_check();
    @(negedge clk_i);
    ev[0] = model_view(0);
    ev[1] = model_view(1);
    compare_view("fixed", {a_hreq, a_igt, a_dgt, a_irv, a_drv, a_ierr, a_derr, a_we,
                           a_be, a_addr, a_wdata, a_irdata, a_drdata}, ev[0]);
    if (check_b)
      compare_view("rr", {b_hreq, b_igt, b_dgt, b_irv, b_drv, b_ierr, b_derr, b_we,
                          b_be, b_addr, b_wdata, b_irdata, b_drdata}, ev[1]);
  endtask

  // Model state advances on the same rising edge the DUTs sample.
  task automatic next();
    if (rst_ni) begin
      if (host_rvalid && mq.size() > 0) void'(mq.pop_front());
      for (int k = 0; k < 2; k++) begin
        if (ev[k].hreq && host_gnt) begin
          mlast[k] = (mown[k] == 1);
          mlock[k] = -1;
        end else if (ev[k].hreq) begin
          mlock[k] = mown[k];
        end
      end
      if (ev[0].hreq && host_gnt) mq.push_back({mown[1] == 1, mown[0] == 1});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 4'h0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    host_gnt = 0; host_rvalid = 0; host_rdata = 0; host_err = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    step_check();
    next();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk_i);
    #1;

    // Requests during reset must not reach the bus.
    instr_req = 1; data_req = 1; host_gnt = 1; host_rvalid = 1;
    step_check();
    chk("reset.host_req", 32'(a_hreq), 32'd0);
    chk("reset.rvalid", 32'({a_irv, a_drv}), 32'd0);
    next();
    clear_inputs();
    rst_ni = 1'b1;
    step_check();
    chk("idle.host_req", 32'(a_hreq), 32'd0);
    next();

    // Contention with fixed priority: data wins.
    instr_req = 1; data_req = 1; host_gnt = 1;
    instr_addr = 32'h0000_1000; data_addr = 32'h2000_0040;
    data_we = 1; data_be = 4'h3; data_wdata = 32'hCAFE_F00D;
    step_check();
    chk("prio.data_gnt", 32'(a_dgt), 32'd1);
    chk("prio.instr_gnt", 32'(a_igt), 32'd0);
    chk("prio.host_addr", a_addr, 32'h2000_0040);
    chk("prio.host_wdata", a_wdata, 32'hCAFE_F00D);
    next();
    clear_inputs();
    do_reset();

    // Round-robin alternation with a response every cycle keeping a slot free.
    instr_req = 1; data_req = 1; host_gnt = 1; host_rvalid = 1;
    instr_addr = 32'h0000_2000; data_addr = 32'h3000_0000; data_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      host_rdata = $urandom;
      step_check();
      chk("rr.grant", 32'({b_dgt, b_igt}), (i % 2 == 0) ? 32'd2 : 32'd1);
      next();
    end
    clear_inputs();
    do_reset();

    // Responses route to owners in grant order.
    instr_req = 1; host_gnt = 1; instr_addr = 32'h0000_0100;
    step_check();
    chk("order.instr_gnt", 32'(a_igt), 32'd1);
    chk("order.instr_fields", 32'({a_we, a_be}), 32'h0F);
    next();
    instr_req = 0; data_req = 1; data_addr = 32'h4000_0008; data_be = 4'hC;
    step_check();
    chk("order.data_gnt", 32'(a_dgt), 32'd1);
    next();
    data_req = 0; host_gnt = 0; host_rvalid = 1; host_rdata = 32'hA5A5_0001;
    step_check();
    chk("order.instr_rdata", a_irdata, 32'hA5A5_0001);
    chk("order.data_rdata0", a_drdata, 32'h0);
    next();
    host_rdata = 32'h0000_BEEF;
    step_check();
    chk("order.data_rdata", a_drdata, 32'h0000_BEEF);
    chk("order.instr_rdata0", a_irdata, 32'h0);
    next();
    clear_inputs();

    // Host stalls: ownership stays with instruction side while data waits.
    instr_req = 1; instr_addr = 32'h0000_0A00;
    data_addr = 32'h5000_0000; data_we = 1; data_be = 4'h1;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) data_req = 1;
      step_check();
      chk("hold.host_addr", a_addr, 32'h0000_0A00);
      chk("hold.data_gnt", 32'(a_dgt), 32'd0);
      next();
    end
    host_gnt = 1;
    step_check();
    chk("hold.instr_gnt", 32'(a_igt), 32'd1);
    next();
    instr_req = 0;
    step_check();
    chk("hold.data_after", 32'(a_dgt), 32'd1);
    next();
    clear_inputs();
    do_reset();

    // Outstanding limit: a same-cycle response frees the slot one cycle later.
    instr_req = 1; host_gnt = 1; instr_addr = 32'h0000_0C00;
    for (int i = 0; i < 2; i++) begin
      step_check();
      chk("limit.grant", 32'(a_igt), 32'd1);
      next();
    end
    step_check();
    chk("limit.full_req", 32'(a_hreq), 32'd0);
    next();
    host_rvalid = 1; host_rdata = 32'h1111_2222;
    step_check();
    chk("limit.pop_cycle_req", 32'(a_hreq), 32'd0);
    chk("limit.pop_rvalid", 32'(a_irv), 32'd1);
    next();
    host_rvalid = 0;
    step_check();
    chk("limit.freed_req", 32'(a_hreq), 32'd1);
    next();

    // Reset with two outstanding, then stray responses must be dropped.
    clear_inputs();
    do_reset();
    host_rvalid = 1; host_rdata = 32'hDEAD_0000;
    for (int i = 0; i < 2; i++) begin
      step_check();
      chk("stray.rvalid", 32'({a_irv, a_drv, b_irv, b_drv}), 32'd0);
      next();
    end
    host_rvalid = 0; instr_req = 1; host_gnt = 1;
    for (int i = 0; i < 2; i++) begin
      step_check();
      chk("stray.empty_req", 32'(a_hreq), 32'd1);
      next();
    end
    clear_inputs();
    do_reset();

    // Random traffic; requesters follow the fixed-priority instance's grants.
    check_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!instr_req && ($urandom % 3 == 0)) begin
        instr_req  = 1;
        instr_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && ($urandom % 3 == 0)) begin
        data_req   = 1;
        data_addr  = $urandom;
        data_we    = 1'($urandom);
        data_be    = 4'($urandom);
        data_wdata = $urandom;
      end
      host_gnt    = 1'($urandom);
      host_rvalid = (mq.size() > 0) ? 1'($urandom) : ($urandom % 8 == 0);
      host_rdata  = $urandom;
      host_err    = ($urandom % 4 == 0);
      step_check();
      next();
      if (ev[0].igt) instr_req = 0;
      if (ev[0].dgt) data_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
